llr_stage_engine: RTL and testbench

- Memory-side master for Multiport_BRAM. Issues paired reads on ports A/B, applies the SC kernel (min-sum f or g) to each 2^p-lane word pair, and writes the result back through the single write port.
- Sits between the SC decoder schedule controller (command source) and the LLR BRAM. Processes one stage node of `len` words per command, fully pipelined at 1 word/cycle.

---
 rtl/llr_stage_engine.sv | 235 +++++++++++++++++++++++
 tb/tb_llr_stage_engine.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/llr_stage_engine.sv
// llr_stage_engine: reads word pairs from the LLR BRAM on ports A/B, applies
// the min-sum f or the g kernel lane by lane, and writes the results back
// through the single write port at one word per cycle.
module llr_stage_engine #(
  parameter  int n          = 5,
  parameter  int p          = 1,
  parameter  int Q          = 6,
  localparam int LANES      = 2**p,
  localparam int DATA_WIDTH = LANES*Q,
  localparam int ADDR_WIDTH = $clog2(2**(n-p)-2+p),
  localparam int LEN_WIDTH  = n-p+1,
  localparam int BETA_WIDTH = 2**(n-1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  op,
  input  logic [ADDR_WIDTH-1:0] src_a,
  input  logic [ADDR_WIDTH-1:0] src_b,
  input  logic [ADDR_WIDTH-1:0] dst,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [BETA_WIDTH-1:0] beta,
  output logic                  busy,
  output logic                  done,
  output logic                  rea,
  output logic                  reb,
  output logic [ADDR_WIDTH-1:0] rd_addra,
  output logic [ADDR_WIDTH-1:0] rd_addrb,
  input  logic [DATA_WIDTH-1:0] douta,
  input  logic [DATA_WIDTH-1:0] doutb,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] din
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [Q-1:0]        MAX_POS = {1'b0, {(Q-1){1'b1}}};
  localparam logic [Q-1:0]        MIN_NEG = {1'b1, {(Q-1){1'b0}}};
  localparam logic signed [Q:0]   G_MAX   = (Q+1)'(2**(Q-1)-1);
  localparam logic signed [Q:0]   G_MIN   = -G_MAX;

  // Magnitude of a two's complement lane; the most negative code saturates.
  function automatic logic [Q-1:0] sat_abs(input logic [Q-1:0] v);
    logic [Q-1:0] r;
    if (v[Q-1]) begin
      if (v == MIN_NEG) r = MAX_POS;
      else              r = -v;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Min-sum f: sign product, minimum magnitude.
  function automatic logic [Q-1:0] f_lane(input logic [Q-1:0] a, input logic [Q-1:0] b);
    logic [Q-1:0] ma;
    logic [Q-1:0] mb;
    logic [Q-1:0] m;
    logic [Q-1:0] r;
    ma = sat_abs(a);
    mb = sat_abs(b);
    m  = (ma < mb) ? ma : mb;
    if (a[Q-1] ^ b[Q-1]) r = -m;
    else                 r = m;
    return r;
  endfunction

  // g: b +/- a at Q+1 bits, saturated to the symmetric Q-bit range.
  function automatic logic [Q-1:0] g_lane(input logic [Q-1:0] a, input logic [Q-1:0] b,
                                          input logic u);
    logic signed [Q:0] ae;
    logic signed [Q:0] be;
    logic signed [Q:0] s;
    logic [Q-1:0]      r;
    ae = $signed({a[Q-1], a});
    be = $signed({b[Q-1], b});
    if (u) s = be - ae;
    else   s = be + ae;
    if (s > G_MAX)      r = MAX_POS;
    else if (s < G_MIN) r = G_MIN[Q-1:0];
    else                r = s[Q-1:0];
    return r;
  endfunction

  state_t                  state_r, state_nx_s;
  logic [LEN_WIDTH-1:0]    rd_k_r, rd_k_nx_s;
  logic                    drain_r, drain_nx_s;
  logic                    rea_nx_s;
  logic [ADDR_WIDTH-1:0]   addra_nx_s, addrb_nx_s;
  logic                    accept_s;

  logic                    op_r;
  logic [ADDR_WIDTH-1:0]   src_a_r, src_b_r, dst_r;
  logic [LEN_WIDTH-1:0]    len_r;
  logic [BETA_WIDTH-1:0]   beta_sh_r;
  logic                    rd_v_r;
  logic [LEN_WIDTH-1:0]    wr_k_r;
  logic [DATA_WIDTH-1:0]   kern_s;

  // Next-state and next read-port values of the command sequencer.
  always_comb begin
    state_nx_s = state_r;
    rd_k_nx_s  = rd_k_r;
    drain_nx_s = drain_r;
    rea_nx_s   = 1'b0;
    addra_nx_s = rd_addra;
    addrb_nx_s = rd_addrb;
    accept_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          if (len != LEN_WIDTH'(0)) begin
            state_nx_s = S_READ;
            rea_nx_s   = 1'b1;
            addra_nx_s = src_a;
            addrb_nx_s = src_b;
            rd_k_nx_s  = LEN_WIDTH'(1);
          end else begin
            state_nx_s = S_DONE;
          end
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_READ: begin
        if (rd_k_r == len_r) begin
          state_nx_s = S_DRAIN;
          drain_nx_s = 1'b0;
        end else begin
          rea_nx_s   = 1'b1;
          addra_nx_s = src_a_r + ADDR_WIDTH'(rd_k_r);
          addrb_nx_s = src_b_r + ADDR_WIDTH'(rd_k_r);
          rd_k_nx_s  = rd_k_r + LEN_WIDTH'(1);
        end
      end
      S_DRAIN: begin
        if (drain_r) state_nx_s = S_DONE;
        else         drain_nx_s = 1'b1;
      end
      S_DONE: begin
        state_nx_s = S_IDLE;
      end
      default: begin
        state_nx_s = S_IDLE;
      end
    endcase
  end

  // Sequencer state plus registered busy/done and read-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_IDLE;
      rd_k_r   <= '0;
      drain_r  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rea      <= 1'b0;
      reb      <= 1'b0;
      rd_addra <= '0;
      rd_addrb <= '0;
    end else begin
      state_r  <= state_nx_s;
      rd_k_r   <= rd_k_nx_s;
      drain_r  <= drain_nx_s;
      busy     <= (state_nx_s != S_IDLE);
      done     <= (state_nx_s == S_DONE);
      rea      <= rea_nx_s;
      reb      <= rea_nx_s;
      rd_addra <= addra_nx_s;
      rd_addrb <= addrb_nx_s;
    end
  end

  // Latch the command fields when a start is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r    <= 1'b0;
      src_a_r <= '0;
      src_b_r <= '0;
      dst_r   <= '0;
      len_r   <= '0;
    end else if (accept_s) begin
      op_r    <= op;
      src_a_r <= src_a;
      src_b_r <= src_b;
      dst_r   <= dst;
      len_r   <= len;
    end else begin
      op_r    <= op_r;
      src_a_r <= src_a_r;
      src_b_r <= src_b_r;
      dst_r   <= dst_r;
      len_r   <= len_r;
    end
  end

  // Lane-wise kernel on the word pair returned by the BRAM this cycle.
  always_comb begin
    kern_s = '0;
    for (int i = 0; i < LANES; i++) begin
      if (op_r) kern_s[i*Q +: Q] = g_lane(douta[i*Q +: Q], doutb[i*Q +: Q], beta_sh_r[i]);
      else      kern_s[i*Q +: Q] = f_lane(douta[i*Q +: Q], doutb[i*Q +: Q]);
    end
  end

  // Write stage: register the kernel result and its address one cycle after read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_v_r    <= 1'b0;
      we        <= 1'b0;
      din       <= '0;
      wr_addr   <= '0;
      wr_k_r    <= '0;
      beta_sh_r <= '0;
    end else begin
      rd_v_r <= rea;
      we     <= rd_v_r;
      if (rd_v_r) begin
        din       <= kern_s;
        wr_addr   <= dst_r + ADDR_WIDTH'(wr_k_r);
        wr_k_r    <= wr_k_r + LEN_WIDTH'(1);
        beta_sh_r <= beta_sh_r >> LANES;
      end else if (accept_s) begin
        wr_k_r    <= '0;
        beta_sh_r <= beta;
      end else begin
        wr_k_r    <= wr_k_r;
        beta_sh_r <= beta_sh_r;
      end
    end
  end

endmodule

// File: tb/tb_llr_stage_engine.sv
// Testbench for llr_stage_engine: behavioural BRAM plus a lane-level golden
// model of the f/g kernels, directed and randomized commands.
module tb_llr_stage_engine;

  localparam int LANES = 2;
  localparam int QW    = 6;
  localparam int DW    = 12;
  localparam int AW    = 4;
  localparam int LW    = 5;
  localparam int BW    = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          op;
  logic [AW-1:0] src_a, src_b, dst;
  logic [LW-1:0] len;
  logic [BW-1:0] beta;
  logic          busy, done, rea, reb, we;
  logic [AW-1:0] rd_addra, rd_addrb, wr_addr;
  logic [DW-1:0] douta, doutb, din;

  logic [DW-1:0] mem [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  llr_stage_engine dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .dst(dst), .len(len), .beta(beta),
    .busy(busy), .done(done), .rea(rea), .reb(reb),
    .rd_addra(rd_addra), .rd_addrb(rd_addrb),
    .douta(douta), .doutb(doutb),
    .we(we), .wr_addr(wr_addr), .din(din)
  );

  always #5 clk = ~clk;

  // Behavioural BRAM: 1-cycle read latency, zero output when not enabled.
  always @(posedge clk) begin
    douta <= rea ? mem[rd_addra] : '0;
    doutb <= reb ? mem[rd_addrb] : '0;
    if (we) mem[wr_addr] <= din;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int lane_val(input logic [DW-1:0] w, input int i);
    int v;
    v = int'(w[i*QW +: QW]);
    if (v >= 32) v -= 64;
    return v;
  endfunction

  function automatic int clamp31(input int v);
    if (v > 31)  return 31;
    if (v < -31) return -31;
    return v;
  endfunction

  function automatic int f_ref(input int a, input int b);
    int ma, mb, m;
    ma = (a < 0) ? -a : a;
    mb = (b < 0) ? -b : b;
    m  = clamp31((ma < mb) ? ma : mb);
    return ((a < 0) != (b < 0)) ? -m : m;
  endfunction

  function automatic int g_ref(input int a, input int b, input bit u);
    return clamp31(u ? (b - a) : (b + a));
  endfunction

  function automatic logic [DW-1:0] word_ref(input logic [DW-1:0] wa, input logic [DW-1:0] wb,
                                             input bit opg, input logic [BW-1:0] bt, input int k);
    logic [DW-1:0] w;
    int r, idx;
    bit u;
    w = '0;
    for (int i = 0; i < LANES; i++) begin
      idx = k*LANES + i;
      u   = (idx < BW) ? bt[idx] : 1'b0;
      r   = opg ? g_ref(lane_val(wa, i), lane_val(wb, i), u)
                : f_ref(lane_val(wa, i), lane_val(wb, i));
      w[i*QW +: QW] = QW'(r);
    end
    return w;
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
  endtask

  // Issue one command, watch the ports cycle by cycle, then compare the BRAM.
  task automatic run_cmd(input bit opg, input int sa, input int sb, input int d,
                         input int ln, input logic [BW-1:0] bt, input bit interfere);
    logic [DW-1:0] snap [DEPTH];
    logic [DW-1:0] expm [DEPTH];
    int busy_cnt, rd_i, wr_i, first_rd, first_wr, last_wr, done_cyc, done_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      snap[i] = mem[i];
      expm[i] = mem[i];
    end
    for (int k = 0; k < ln; k++)
      expm[(d+k) % DEPTH] = word_ref(snap[(sa+k) % DEPTH], snap[(sb+k) % DEPTH], opg, bt, k);
    busy_cnt = 0; rd_i = 0; wr_i = 0; first_rd = -1; first_wr = -1;
    last_wr = -1; done_cyc = -1; done_cnt = 0;
    @(negedge clk);
    start = 1'b1; op = opg; src_a = AW'(sa); src_b = AW'(sb); dst = AW'(d);
    len = LW'(ln); beta = bt;
    for (int c = 1; c <= ln + 10; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      check("reb_follows_rea", int'(reb), int'(rea));
      if (rea) begin
        check("rd_addra", int'(rd_addra), (sa + rd_i) % DEPTH);
        check("rd_addrb", int'(rd_addrb), (sb + rd_i) % DEPTH);
        if (first_rd < 0) first_rd = c;
        rd_i++;
      end
      if (we) begin
        check("wr_addr", int'(wr_addr), (d + wr_i) % DEPTH);
        if (first_wr < 0) first_wr = c;
        last_wr = c;
        wr_i++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c == 1 && interfere) begin
        start = 1'b1; op = ~opg; src_a = AW'(sa + 3); src_b = AW'(sb + 7);
        dst = AW'(d + 5); len = LW'(ln + 1); beta = ~bt;
      end else begin
        start = 1'b0;
      end
    end
    check("reads", rd_i, ln);
    check("writes", wr_i, ln);
    check("done_pulses", done_cnt, 1);
    if (ln > 0) begin
      check("busy_cycles", busy_cnt, ln + 3);
      check("first_read_cycle", first_rd, 1);
      check("write_latency", first_wr - first_rd, 2);
      check("done_after_last_write", done_cyc, last_wr + 1);
    end else begin
      check("busy_cycles_len0", busy_cnt, 1);
      check("done_cycle_len0", done_cyc, 1);
    end
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("mem[%0d]", i), int'(mem[i]), int'(expm[i]));
  endtask

  initial begin
    int base, a, b, d;
    rst = 1'b1; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0; dst = '0;
    len = '0; beta = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rea", int'(rea), 0);
    check("rst_reb", int'(reb), 0);
    check("rst_we", int'(we), 0);
    check("rst_din", int'(din), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_rd_addra", int'(rd_addra), 0);
    check("rst_rd_addrb", int'(rd_addrb), 0);
    rst = 1'b0;
    @(negedge clk);

    // f example: A=(5,-3), B=(-2,-7) -> (-2,3)
    fill_mem();
    mem[2] = 12'hF45; mem[6] = 12'hE7E;
    run_cmd(1'b0, 2, 6, 10, 1, 16'h0000, 1'b0);
    check("f_example_word", int'(mem[10]), 12'h0FE);

    // g example: A=(20,-31), B=(20,-32), beta=0010 -> word0 (31,-1)
    fill_mem();
    mem[0] = 12'h854; mem[4] = 12'h814;
    run_cmd(1'b1, 0, 4, 8, 2, 16'h0002, 1'b0);
    check("g_example_word0", int'(mem[8]), 12'hFDF);

    // len=0: no BRAM access, done one cycle after acceptance
    fill_mem();
    run_cmd(1'b0, 1, 2, 3, 0, 16'h0000, 1'b1);

    // start while busy must not disturb the running command
    fill_mem();
    run_cmd(1'b1, 0, 5, 10, 4, 16'h00A5, 1'b1);

    // streaming full-length words, fully in place
    fill_mem();
    run_cmd(1'b0, 0, 0, 0, 16, 16'h0000, 1'b0);
    fill_mem();
    run_cmd(1'b1, 0, 0, 0, 16, 16'($urandom), 1'b0);

    // in-place g over alpha-right
    fill_mem();
    run_cmd(1'b1, 0, 8, 8, 8, 16'($urandom), 1'b0);

    // reset in the middle of a len=4 command
    fill_mem();
    @(negedge clk);
    start = 1'b1; op = 1'b0; src_a = 4'd0; src_b = 4'd5; dst = 4'd10; len = 5'd4; beta = '0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_rea", int'(rea), 1);
    check("pre_reset_we", int'(we), 1);
    #1 rst = 1'b1;
    #1;
    check("abort_rea", int'(rea), 0);
    check("abort_reb", int'(reb), 0);
    check("abort_we", int'(we), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 1) rst = 1'b0;
      check("no_done_after_abort", int'(done), 0);
      check("idle_after_abort", int'(busy), 0);
    end
    fill_mem();
    run_cmd(1'b1, 1, 6, 11, 4, 16'h005A, 1'b0);

    // randomized commands over disjoint (or in-place on B) ranges
    for (int t = 0; t < 20; t++) begin
      fill_mem();
      base = int'($urandom_range(0, 15));
      a = base % DEPTH;
      b = (base + 5) % DEPTH;
      d = (base + 10) % DEPTH;
      if ($urandom_range(0, 1) == 1) begin
        int tmp;
        tmp = a; a = b; b = tmp;
      end
      if ($urandom_range(0, 3) == 0) d = b;
      run_cmd(1'($urandom_range(0, 1)), a, b, d, int'($urandom_range(1, 5)),
              16'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
